// File: rtl/switch_matrix_sequencer.sv
// Queues crosspoint commands and sequences them onto MT8816 analog switch chips.
// Define SWITCH_SHADOW_EN to add a readable shadow copy of the crosspoint map.
//   state | meaning
//   IDLE  | waiting; pops the next command when the FIFO is non-empty
//   RESET | one cycle entered on rst_n or chip reset; all chip selects dropped
//   SETUP | CS and address driven, waiting for STROBE
//   STROB | STROBE high, crosspoint latched by the chip
//   CLEAR | RESET_SW held high for T_RESET cycles
//   HOLD  | STROBE low, CS still high
module switch_matrix_sequencer #(
  parameter int NUM_SW     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int T_RESET    = 6,
  parameter int T_SETUP    = 2,
  parameter int T_STROBE   = 3,
  parameter int T_HOLD     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic [3:0]        op,
  input  logic [15:0]       data_in,
  output logic              rdy,
  output logic [3:0]        state,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              err,
  output logic [15:0]       data_out,
  output logic [NUM_SW-1:0] RESET_SW,
  output logic [NUM_SW-1:0] CS_SW,
  output logic [3:0]        AX,
  output logic [2:0]        AY,
  output logic              STROBE,
  output logic              DATA
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 8;
  localparam int EW = 11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_SETUP = 3'd2,
    S_STROB = 3'd3,
    S_CLEAR = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_SW-1:0] r_reset_sw, w_reset_sw_nxt;
  logic [NUM_SW-1:0] r_cs_sw, w_cs_sw_nxt;
  logic              r_strobe, w_strobe_nxt;
  logic [3:0]        r_ax, w_ax_nxt;
  logic [2:0]        r_ay, w_ay_nxt;
  logic              r_data, w_data_nxt;
  logic [2:0]        r_chip, w_chip_nxt;
  logic              r_err;

  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_flush, w_push_req, w_bad_chip, w_push, w_push_err, w_pop;
  logic [EW-1:0]     w_head;
  logic [3:0]        w_ax_phys;

  // Logical-to-physical X mapping: the MT8816 skips codes 6/7 in its X decode.
  function automatic logic [3:0] map_ax(input logic [3:0] ax);
    if (ax >= 4'd6 && ax <= 4'd11) map_ax = ax + 4'd2;
    else if (ax == 4'd12)          map_ax = 4'd6;
    else if (ax == 4'd13)          map_ax = 4'd7;
    else                           map_ax = ax;
  endfunction

  assign w_flush    = cs & op[0];
  assign w_push_req = cs & op[1] & ~op[0];
  assign w_bad_chip = ({29'd0, data_in[6:4]} >= NUM_SW);
  assign fifo_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (r_count == '0);
  assign w_push     = w_push_req & ~w_bad_chip & ~fifo_full;
  assign w_push_err = w_push_req & (w_bad_chip | fifo_full);
  assign w_pop      = (r_state == S_IDLE) & ~fifo_empty & ~w_flush;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_ax_phys  = map_ax(data_in[3:0]);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {data_in[6:4], w_ax_phys, data_in[9:7], data_in[11]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_reset_sw_nxt = r_reset_sw;
    w_cs_sw_nxt    = r_cs_sw;
    w_strobe_nxt   = r_strobe;
    w_ax_nxt       = r_ax;
    w_ay_nxt       = r_ay;
    w_data_nxt     = r_data;
    w_chip_nxt     = r_chip;
    if (w_flush) begin
      w_state_nxt    = S_RESET;
      w_reset_sw_nxt = '0;
      w_cs_sw_nxt    = '0;
      w_strobe_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          w_state_nxt    = S_CLEAR;
          w_reset_sw_nxt = '1;
          w_cs_sw_nxt    = '0;
          w_strobe_nxt   = 1'b0;
          w_cnt_nxt      = CW'(T_RESET - 1);
        end
        S_CLEAR: begin
          if (r_cnt == '0) begin
            w_state_nxt    = S_IDLE;
            w_reset_sw_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (!fifo_empty) begin
            w_state_nxt = S_SETUP;
            w_chip_nxt  = w_head[10:8];
            w_ax_nxt    = w_head[7:4];
            w_ay_nxt    = w_head[3:1];
            w_data_nxt  = w_head[0];
            w_cs_sw_nxt = NUM_SW'(1) << w_head[10:8];
            w_cnt_nxt   = CW'(T_SETUP - 1);
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            w_state_nxt  = S_STROB;
            w_strobe_nxt = 1'b1;
            w_cnt_nxt    = CW'(T_STROBE - 1);
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_STROB: begin
          if (r_cnt == '0) begin
            w_state_nxt  = S_HOLD;
            w_strobe_nxt = 1'b0;
            w_cnt_nxt    = CW'(T_HOLD - 1);
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            w_state_nxt = S_IDLE;
            w_cs_sw_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: w_state_nxt = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RESET;
      r_cnt      <= '0;
      r_reset_sw <= '0;
      r_cs_sw    <= '0;
      r_strobe   <= 1'b0;
      r_ax       <= '0;
      r_ay       <= '0;
      r_data     <= 1'b0;
      r_chip     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_reset_sw <= w_reset_sw_nxt;
      r_cs_sw    <= w_cs_sw_nxt;
      r_strobe   <= w_strobe_nxt;
      r_ax       <= w_ax_nxt;
      r_ay       <= w_ay_nxt;
      r_data     <= w_data_nxt;
      r_chip     <= w_chip_nxt;
    end
  end

  // Set wins over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_err <= 1'b0;
    else if (w_push_err)       r_err <= 1'b1;
    else if (cs & op[3])       r_err <= 1'b0;
  end

`ifdef SWITCH_SHADOW_EN
  localparam int SIW = $clog2(NUM_SW * 8);
  logic [15:0]    r_shadow [NUM_SW*8];
  logic [15:0]    r_data_out;
  logic [SIW-1:0] w_wr_row, w_rd_row;
  logic           w_unused;

  assign w_wr_row = SIW'({r_chip, r_ay});
  assign w_rd_row = SIW'({data_in[6:4], data_in[9:7]});
  assign w_unused = ^{data_in[15:12], data_in[10]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SW*8; i++) r_shadow[i] <= '0;
      r_data_out <= '0;
    end else begin
      if (cs & op[2]) r_data_out <= w_bad_chip ? 16'd0 : r_shadow[w_rd_row];
      if (w_flush) begin
        for (int i = 0; i < NUM_SW*8; i++) r_shadow[i] <= '0;
      end else if (w_strobe_nxt & ~r_strobe) begin
        r_shadow[w_wr_row][r_ax] <= r_data;
      end
    end
  end

  assign data_out = r_data_out;
`else
  logic w_unused;
  assign w_unused = ^{data_in[15:12], data_in[10], op[2], r_chip};
  assign data_out = '0;
`endif

  assign rdy      = (r_state == S_IDLE) & fifo_empty;
  assign state    = {1'b0, r_state};
  assign err      = r_err;
  assign RESET_SW = r_reset_sw;
  assign CS_SW    = r_cs_sw;
  assign STROBE   = r_strobe;
  assign AX       = r_ax;
  assign AY       = r_ay;
  assign DATA     = r_data;
endmodule

// File: tb/tb_switch_matrix_sequencer.sv
// Self-checking bench for switch_matrix_sequencer against a command-phase reference model.
// Shadow checks follow SWITCH_SHADOW_EN when the bench is built with it.
module tb_switch_matrix_sequencer;
  localparam int T_RESET  = 6;
  localparam int T_SETUP  = 2;
  localparam int T_STROBE = 3;
  localparam int T_HOLD   = 2;
  localparam int CMD_LEN  = 1 + T_SETUP + T_STROBE + T_HOLD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [15:0] data_in = 16'd0;
  logic        rdy, fifo_full, fifo_empty, err, STROBE, DATA;
  logic [3:0]  state, AX;
  logic [2:0]  AY;
  logic [15:0] data_out;
  logic [1:0]  RESET_SW, CS_SW;

  switch_matrix_sequencer #(
    .NUM_SW(2), .FIFO_DEPTH(4), .T_RESET(T_RESET),
    .T_SETUP(T_SETUP), .T_STROBE(T_STROBE), .T_HOLD(T_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .op(op), .data_in(data_in),
    .rdy(rdy), .state(state), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .err(err), .data_out(data_out), .RESET_SW(RESET_SW), .CS_SW(CS_SW),
    .AX(AX), .AY(AY), .STROBE(STROBE), .DATA(DATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] chip;
    logic [3:0] ax;
    logic [2:0] ay;
    logic       d;
  } cmd_t;

  // Reference model: command queue plus a phase counter within the current command.
  cmd_t        m_q[$];
  cmd_t        m_cur;
  int          m_busy;
  int          m_init_ph;
  bit          m_in_init;
  bit          m_err;
  logic [15:0] m_dout;
  logic [15:0] m_sh [2][8];

  int checks = 0;
  int failures = 0;

  logic [36:0] dut_vec;
  assign dut_vec = {state, CS_SW, STROBE, RESET_SW, AX, AY, DATA, rdy, err,
                    fifo_full, fifo_empty, data_out};

  function automatic logic [3:0] phys_ax(input logic [3:0] a);
    if (a >= 4'd6 && a <= 4'd11) return a + 4'd2;
    if (a == 4'd12) return 4'd6;
    if (a == 4'd13) return 4'd7;
    return a;
  endfunction

  function automatic logic [15:0] make_din(input int chip, input int ax, input int ay, input int d);
    logic [15:0] v;
    v = 16'd0;
    v[3:0]  = 4'(ax);
    v[6:4]  = 3'(chip);
    v[9:7]  = 3'(ay);
    v[11]   = (d != 0);
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur     = '{3'd0, 4'd0, 3'd0, 1'b0};
    m_busy    = 0;
    m_in_init = 1'b1;
    m_init_ph = 0;
    m_err     = 1'b0;
    m_dout    = 16'd0;
    for (int c = 0; c < 2; c++) for (int r = 0; r < 8; r++) m_sh[c][r] = 16'd0;
  endtask

  task automatic m_step(input logic c, input logic [3:0] o, input logic [15:0] d);
    bit flush, push_req, full, bad;
    flush    = c && o[0];
    push_req = c && o[1] && !o[0];
    full     = (m_q.size() >= 4);
    bad      = (d[6:4] >= 3'd2);
`ifdef SWITCH_SHADOW_EN
    if (c && o[2]) m_dout = bad ? 16'd0 : m_sh[d[4]][d[9:7]];
`endif
    if (push_req && (bad || full)) m_err = 1'b1;
    else if (c && o[3])            m_err = 1'b0;
    if (flush) begin
      m_q.delete();
      m_busy    = 0;
      m_in_init = 1'b1;
      m_init_ph = 0;
      for (int ci = 0; ci < 2; ci++) for (int r = 0; r < 8; r++) m_sh[ci][r] = 16'd0;
      return;
    end
    if (m_in_init) begin
      m_init_ph++;
      if (m_init_ph > T_RESET) m_in_init = 1'b0;
    end else if (m_busy > 0) begin
      m_busy = (m_busy == CMD_LEN - 1) ? 0 : m_busy + 1;
      if (m_busy == T_SETUP + 1) m_sh[m_cur.chip[0]][m_cur.ay][m_cur.ax] = m_cur.d;
    end else if (m_q.size() > 0) begin
      m_cur  = m_q.pop_front();
      m_busy = 1;
    end
    if (push_req && !bad && !full) m_q.push_back('{d[6:4], phys_ax(d[3:0]), d[9:7], d[11]});
  endtask

  function automatic logic [36:0] m_vec();
    logic [3:0] st;
    logic [1:0] csv, rsw;
    logic       stb, rdy_e;
    st = 4'd0; csv = 2'b00; rsw = 2'b00; stb = 1'b0;
    if (m_in_init) begin
      st  = (m_init_ph == 0) ? 4'd1 : 4'd4;
      rsw = (m_init_ph >= 1) ? 2'b11 : 2'b00;
    end else if (m_busy > 0) begin
      csv = 2'b01 << m_cur.chip;
      stb = (m_busy > T_SETUP) && (m_busy <= T_SETUP + T_STROBE);
      if (m_busy <= T_SETUP)                 st = 4'd2;
      else if (m_busy <= T_SETUP + T_STROBE) st = 4'd3;
      else                                   st = 4'd5;
    end
    rdy_e = (st == 4'd0) && (m_q.size() == 0);
    return {st, csv, stb, rsw, m_cur.ax, m_cur.ay, m_cur.d, rdy_e, m_err,
            (m_q.size() == 4), (m_q.size() == 0), m_dout};
  endfunction

  task automatic tick(input logic c, input logic [3:0] o, input logic [15:0] d);
    cs = c; op = o; data_in = d;
    @(posedge clk);
    m_step(c, o, d);
    #1;
  endtask

  task automatic test_reset();
    int hi_cnt;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (state !== 4'd1) begin failures++; $display("FAIL rst_state got=%0d exp=1", state); end
    checks++;
    if ({RESET_SW, CS_SW, STROBE, AX, AY, DATA, data_out} !== 31'd0) begin
      failures++; $display("FAIL rst_outputs got=%h exp=0", {RESET_SW, CS_SW, STROBE, AX, AY, DATA, data_out});
    end
    checks++;
    if ({err, rdy, fifo_empty} !== 3'b001) begin
      failures++; $display("FAIL rst_flags got=%b exp=001", {err, rdy, fifo_empty});
    end
    checks++;
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < T_RESET + 4; i++) begin
      tick(1'b0, 4'd0, 16'd0);
      if (RESET_SW === 2'b11) hi_cnt++;
      if (dut_vec !== m_vec()) begin failures++; $display("FAIL reset_seq cyc=%0d got=%h exp=%h", i, dut_vec, m_vec()); end
      checks++;
    end
    if (hi_cnt !== T_RESET) begin failures++; $display("FAIL reset_sw_len got=%0d exp=%0d", hi_cnt, T_RESET); end
    checks++;
    if ({state, rdy} !== 5'b0000_1) begin failures++; $display("FAIL reset_done got=%b exp=00001", {state, rdy}); end
    checks++;
  endtask

  task automatic test_single_cmd();
    int cs_rise, st_rise, st_fall, cs_fall;
    logic [1:0] pcs;
    logic pst;
    cs_rise = -1; st_rise = -1; st_fall = -1; cs_fall = -1;
    pcs = CS_SW; pst = STROBE;
    tick(1'b1, 4'b0010, make_din(1, 12, 5, 1));
    for (int i = 0; i < CMD_LEN + 2; i++) begin
      tick(1'b0, 4'd0, 16'd0);
      if (dut_vec !== m_vec()) begin failures++; $display("FAIL single_cmd cyc=%0d got=%h exp=%h", i, dut_vec, m_vec()); end
      checks++;
      if (CS_SW !== 2'b00) begin
        if ({CS_SW, AX, AY, DATA} !== {2'b10, 4'd6, 3'd5, 1'b1}) begin
          failures++; $display("FAIL single_addr got=%h exp=%h", {CS_SW, AX, AY, DATA}, {2'b10, 4'd6, 3'd5, 1'b1});
        end
        checks++;
      end
      if (pcs == 2'b00 && CS_SW != 2'b00) cs_rise = i;
      if (pcs != 2'b00 && CS_SW == 2'b00) cs_fall = i;
      if (!pst && STROBE) st_rise = i;
      if (pst && !STROBE) st_fall = i;
      pcs = CS_SW; pst = STROBE;
    end
    if (st_rise - cs_rise !== T_SETUP) begin failures++; $display("FAIL setup_time got=%0d exp=%0d", st_rise - cs_rise, T_SETUP); end
    checks++;
    if (st_fall - st_rise !== T_STROBE) begin failures++; $display("FAIL strobe_len got=%0d exp=%0d", st_fall - st_rise, T_STROBE); end
    checks++;
    if (cs_fall - st_fall !== T_HOLD) begin failures++; $display("FAIL hold_time got=%0d exp=%0d", cs_fall - st_fall, T_HOLD); end
    checks++;
  endtask

  task automatic test_back_to_back();
    cmd_t sent[4];
    int rises[$];
    logic [3:0] rise_ax[$];
    logic [1:0] pcs;
    logic [15:0] d;
    tick(1'b1, 4'b0001, 16'd0);
    for (int k = 0; k < 5; k++) begin
      d = make_din($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1));
      if (k < 4) sent[k] = '{d[6:4], phys_ax(d[3:0]), d[9:7], d[11]};
      tick(1'b1, 4'b0010, d);
    end
    if ({err, fifo_full} !== 2'b11) begin failures++; $display("FAIL b2b_overflow got=%b exp=11", {err, fifo_full}); end
    checks++;
    pcs = CS_SW;
    for (int i = 0; i < 4 * CMD_LEN + 8; i++) begin
      tick(1'b0, 4'd0, 16'd0);
      if (dut_vec !== m_vec()) begin failures++; $display("FAIL b2b cyc=%0d got=%h exp=%h", i, dut_vec, m_vec()); end
      checks++;
      if (pcs == 2'b00 && CS_SW != 2'b00) begin rises.push_back(i); rise_ax.push_back(AX); end
      pcs = CS_SW;
    end
    if (rises.size() !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", rises.size()); end
    checks++;
    for (int k = 0; k < 4 && k < rises.size(); k++) begin
      if (rise_ax[k] !== sent[k].ax) begin failures++; $display("FAIL b2b_order k=%0d got=%0d exp=%0d", k, rise_ax[k], sent[k].ax); end
      checks++;
      if (k > 0) begin
        if (rises[k] - rises[k-1] !== CMD_LEN) begin
          failures++; $display("FAIL b2b_period k=%0d got=%0d exp=%0d", k, rises[k] - rises[k-1], CMD_LEN);
        end
        checks++;
      end
    end
    tick(1'b1, 4'b1000, 16'd0);
  endtask

  task automatic test_bad_chip();
    tick(1'b1, 4'b1000, 16'd0);
    if (err !== 1'b0) begin failures++; $display("FAIL bad_pre_clear got=%b exp=0", err); end
    checks++;
    tick(1'b1, 4'b0010, make_din($urandom_range(2, 7), 3, 1, 1));
    if (err !== 1'b1) begin failures++; $display("FAIL bad_chip_err got=%b exp=1", err); end
    checks++;
    for (int i = 0; i < CMD_LEN; i++) begin
      tick(1'b0, 4'd0, 16'd0);
      if (CS_SW !== 2'b00 || dut_vec !== m_vec()) begin
        failures++; $display("FAIL bad_chip_idle cyc=%0d got=%h exp=%h", i, dut_vec, m_vec());
      end
      checks++;
    end
    tick(1'b1, 4'b1000, 16'd0);
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
    checks++;
    tick(1'b1, 4'b1010, make_din(5, 0, 0, 0));
    if (err !== 1'b1) begin failures++; $display("FAIL err_set_wins got=%b exp=1", err); end
    checks++;
    tick(1'b1, 4'b1000, 16'd0);
  endtask

  task automatic test_abort();
    tick(1'b1, 4'b0010, make_din(0, 4, 3, 1));
    tick(1'b1, 4'b0010, make_din(1, 7, 2, 0));
    tick(1'b0, 4'd0, 16'd0);
    tick(1'b0, 4'd0, 16'd0);
    if ({state, STROBE} !== {4'd3, 1'b1}) begin failures++; $display("FAIL abort_pre got=%h exp=%h", {state, STROBE}, {4'd3, 1'b1}); end
    checks++;
    tick(1'b1, 4'b0011, make_din(0, 1, 1, 1));
    if ({STROBE, CS_SW, state, fifo_empty} !== {1'b0, 2'b00, 4'd1, 1'b1}) begin
      failures++; $display("FAIL abort got=%b exp=%b", {STROBE, CS_SW, state, fifo_empty}, {1'b0, 2'b00, 4'd1, 1'b1});
    end
    checks++;
    for (int i = 0; i < T_RESET + 3; i++) begin
      tick(1'b0, 4'd0, 16'd0);
      if (dut_vec !== m_vec()) begin failures++; $display("FAIL abort_recover cyc=%0d got=%h exp=%h", i, dut_vec, m_vec()); end
      checks++;
    end
  endtask

  task automatic test_shadow();
    logic [15:0] exp_row;
`ifdef SWITCH_SHADOW_EN
    exp_row = 16'h0800;
`else
    exp_row = 16'h0000;
`endif
    tick(1'b1, 4'b0001, 16'd0);
    for (int i = 0; i < T_RESET + 2; i++) tick(1'b0, 4'd0, 16'd0);
    tick(1'b1, 4'b0010, make_din(0, 9, 2, 1));
    for (int i = 0; i < CMD_LEN + 1; i++) tick(1'b0, 4'd0, 16'd0);
    tick(1'b1, 4'b0100, make_din(0, 0, 2, 0));
    if (data_out !== exp_row) begin failures++; $display("FAIL shadow_read got=%h exp=%h", data_out, exp_row); end
    checks++;
    if (dut_vec !== m_vec()) begin failures++; $display("FAIL shadow_vec got=%h exp=%h", dut_vec, m_vec()); end
    checks++;
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [15:0] d;
    logic        c;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 1) == 1);
      o = 4'($urandom_range(0, 15));
      if (o[0] && $urandom_range(0, 15) != 0) o[0] = 1'b0;
      d = 16'($urandom);
      d[6:4] = 3'($urandom_range(0, 2));
      tick(c, o, d);
      if (dut_vec !== m_vec()) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, m_vec()); end
      checks++;
    end
    tick(1'b0, 4'd0, 16'd0);
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_back_to_back();
    test_bad_chip();
    test_abort();
    test_shadow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
